// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master (cfg in: CPOL/CPHA/lsb_first/clk_div/ss_sel/tx_data; handshake: start/busy/done/err/rx_data; SPI: sclk/mosi/miso/ss_n)
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 3,
  parameter int DIV_W = 8,
  parameter int SEL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, FINISH} state_t;
  localparam int EW = $clog2(2 * DATA_W);
  state_t state;
  logic cpol_l, cpha_l, lsb_l;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W:0] cnt;
  logic [EW-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_next, rx_next;
  logic tick, lead, last, bad_sel;
  assign tick = cnt == {1'b0, div_l} + (DIV_W+1)'(1);
  assign lead = ~edge_cnt[0];
  assign last = edge_cnt == EW'(2 * DATA_W - 1);
  assign tx_next = lsb_l ? tx_sr >> 1 : tx_sr << 1;
  assign rx_next = lsb_l ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
  assign bad_sel = int'(ss_sel) >= NUM_SS;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
      div_l <= '0;
      cnt <= '0;
      edge_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      ss_n <= '1;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (state != IDLE) cnt <= tick ? (DIV_W+1)'(1) : cnt + (DIV_W+1)'(1);
      case (state)
        IDLE: begin
          sclk <= cpol_l;
          if (start && bad_sel) err <= 1'b1;
          else if (start) begin
            cpol_l <= CPOL;
            cpha_l <= CPHA;
            lsb_l <= lsb_first;
            div_l <= clk_div;
            sclk <= CPOL;
            tx_sr <= tx_data;
            cnt <= (DIV_W+1)'(1);
            edge_cnt <= '0;
            busy <= 1'b1;
            ss_n <= ~(NUM_SS'(1) << ss_sel);
            state <= SETUP;
            if (!CPHA) mosi <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
          end
        end
        SETUP, XFER: begin
          if (tick) begin
            sclk <= ~sclk;
            edge_cnt <= edge_cnt + EW'(1);
            state <= last ? FINISH : XFER;
            // sample when (leading, CPHA=0) or (trailing, CPHA=1); otherwise this is a drive edge
            if (lead ^ cpha_l) rx_sr <= rx_next;
            else if (cpha_l || !last) begin
              mosi <= cpha_l ? (lsb_l ? tx_sr[0] : tx_sr[DATA_W-1]) : (lsb_l ? tx_next[0] : tx_next[DATA_W-1]);
              tx_sr <= tx_next;
            end
          end
        end
        FINISH: begin
          if (tick) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            ss_n <= '1;
            rx_data <= rx_sr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: scoreboard bench for spi_master_param (8-bit/3-slave with slave model, 16-bit/4-slave loopback)
module tb_spi_master_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic cpol_a = 0, cpha_a = 0, lsb_a = 0, start_a = 0, miso_a = 0;
  logic [7:0] div_a = 0, tx_a = 0, rx_a;
  logic [1:0] sel_a = 0;
  logic busy_a, done_a, err_a, sclk_a, mosi_a;
  logic [2:0] ss_n_a;
  logic cpol_b = 0, cpha_b = 0, lsb_b = 0, start_b = 0;
  logic [7:0] div_b = 0;
  logic [1:0] sel_b = 0;
  logic [15:0] tx_b = 0, rx_b;
  logic busy_b, done_b, err_b, sclk_b, mosi_b;
  logic [3:0] ss_n_b;
  logic [7:0] exp_a[$];
  logic [15:0] exp_b[$];
  spi_master_param dut_a (
    .clk(clk), .reset(reset), .CPOL(cpol_a), .CPHA(cpha_a), .lsb_first(lsb_a),
    .clk_div(div_a), .ss_sel(sel_a), .start(start_a), .tx_data(tx_a), .rx_data(rx_a),
    .busy(busy_a), .done(done_a), .err(err_a), .sclk(sclk_a), .mosi(mosi_a),
    .miso(miso_a), .ss_n(ss_n_a)
  );
  spi_master_param #(.DATA_W(16), .NUM_SS(4)) dut_b (
    .clk(clk), .reset(reset), .CPOL(cpol_b), .CPHA(cpha_b), .lsb_first(lsb_b),
    .clk_div(div_b), .ss_sel(sel_b), .start(start_b), .tx_data(tx_b), .rx_data(rx_b),
    .busy(busy_b), .done(done_b), .err(err_b), .sclk(sclk_b), .mosi(mosi_b),
    .miso(mosi_b), .ss_n(ss_n_b)
  );
  // behavioural SPI slave for dut_a, evaluated mid-cycle
  logic s_cpol = 0, s_cpha = 0, s_lsb = 0, s_sel_prev = 0, s_prev = 0;
  logic [7:0] s_word = 0, s_out = 0, s_got = 0;
  always @(negedge clk) begin
    if (ss_n_a == 3'b111) s_sel_prev = 1'b0;
    else if (!s_sel_prev) begin
      s_sel_prev = 1'b1;
      s_prev = sclk_a;
      s_out = s_word;
      s_got = 8'h00;
      if (!s_cpha) miso_a = s_lsb ? s_out[0] : s_out[7];
    end else if (sclk_a != s_prev) begin
      s_prev = sclk_a;
      if ((sclk_a != s_cpol) ^ s_cpha) s_got = s_lsb ? {mosi_a, s_got[7:1]} : {s_got[6:0], mosi_a};
      else if (s_cpha) begin
        miso_a = s_lsb ? s_out[0] : s_out[7];
        s_out = s_lsb ? s_out >> 1 : s_out << 1;
      end else begin
        s_out = s_lsb ? s_out >> 1 : s_out << 1;
        miso_a = s_lsb ? s_out[0] : s_out[7];
      end
    end
  end
  task automatic xfer_a(input logic cp, ch, lf, input logic [7:0] dv, input logic [1:0] sl,
                        input logic [7:0] tx, sw, input int glitch, input bit chain, input string nm);
    int h, dn, edges, first, last, busy_n, ss_bad, dones, done_at, errs;
    logic prev;
    logic [7:0] got;
    h = int'(dv) + 1;
    dn = 1 + 17 * h;
    edges = 0; first = 0; last = 0; busy_n = 0; ss_bad = 0; dones = 0; done_at = 0; errs = 0;
    cpol_a = cp; cpha_a = ch; lsb_a = lf; div_a = dv; sel_a = sl; tx_a = tx;
    s_cpol = cp; s_cpha = ch; s_lsb = lf; s_word = sw;
    exp_a.push_back(sw);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    prev = cp;
    for (int k = 1; k <= dn; k++) begin
      if (k == glitch) begin start_a = 1'b1; tx_a = 8'hFF; end
      else if (k == glitch + 1) start_a = 1'b0;
      if (sclk_a !== prev) begin edges++; if (edges == 1) first = k; last = k; prev = sclk_a; end
      if (busy_a) busy_n++;
      if (err_a) errs++;
      if (k < dn && ss_n_a !== ~(3'b001 << sl)) ss_bad++;
      if (done_a) begin dones++; done_at = k; end
      if (k < dn) begin @(posedge clk); #1; end
    end
    start_a = 1'b0;
    got = exp_a.pop_front();
    checks++; if (done_at != dn || dones != 1) begin failures++; $display("FAIL %s done_cycle got=%0d/%0d pulses exp=%0d/1", nm, done_at, dones, dn); end
    checks++; if (rx_a !== got) begin failures++; $display("FAIL %s rx_data got=%h exp=%h", nm, rx_a, got); end
    checks++; if (s_got !== tx) begin failures++; $display("FAIL %s slave_rx got=%h exp=%h", nm, s_got, tx); end
    checks++; if (busy_n != 17 * h) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, busy_n, 17 * h); end
    checks++; if (edges != 16 || first != 1 + h || last != 1 + 16 * h) begin failures++; $display("FAIL %s sclk_edges got=%0d first=%0d last=%0d exp=16 %0d %0d", nm, edges, first, last, 1 + h, 1 + 16 * h); end
    checks++; if (ss_bad != 0 || ss_n_a !== 3'b111) begin failures++; $display("FAIL %s ss_n bad_cycles=%0d final=%b exp=0 111", nm, ss_bad, ss_n_a); end
    checks++; if (sclk_a !== cp) begin failures++; $display("FAIL %s sclk_idle got=%b exp=%b", nm, sclk_a, cp); end
    checks++; if (errs != 0) begin failures++; $display("FAIL %s err_pulses got=%0d exp=0", nm, errs); end
    if (chain) return;
    @(posedge clk); #1;
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL %s after_done done=%b busy=%b exp=0 0", nm, done_a, busy_a); end
    repeat (2) begin @(posedge clk); #1; end
  endtask
  task automatic xfer_b(input logic cp, ch, input logic [7:0] dv, input logic [15:0] tx, input string nm);
    int h, dn, edges, busy_n, dones, done_at;
    logic prev;
    logic [15:0] got;
    h = int'(dv) + 1;
    dn = 1 + 33 * h;
    edges = 0; busy_n = 0; dones = 0; done_at = 0;
    cpol_b = cp; cpha_b = ch; lsb_b = 1'b0; div_b = dv; sel_b = 2'd3; tx_b = tx;
    exp_b.push_back(tx);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    prev = cp;
    for (int k = 1; k <= dn; k++) begin
      if (sclk_b !== prev) begin edges++; prev = sclk_b; end
      if (busy_b) busy_n++;
      if (done_b) begin dones++; done_at = k; end
      if (k < dn) begin @(posedge clk); #1; end
    end
    got = exp_b.pop_front();
    checks++; if (done_at != dn || dones != 1) begin failures++; $display("FAIL %s done_cycle got=%0d/%0d exp=%0d/1", nm, done_at, dones, dn); end
    checks++; if (rx_b !== got) begin failures++; $display("FAIL %s rx_data got=%h exp=%h", nm, rx_b, got); end
    checks++; if (busy_n != 33 * h || edges != 32) begin failures++; $display("FAIL %s busy/edges got=%0d/%0d exp=%0d/32", nm, busy_n, edges, 33 * h); end
    repeat (2) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({sclk_a, mosi_a, busy_a, done_a, err_a} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {sclk_a, mosi_a, busy_a, done_a, err_a}); end
    checks++; if (ss_n_a !== 3'b111 || rx_a !== 8'h00) begin failures++; $display("FAIL reset_ss_rx got=%b %h exp=111 00", ss_n_a, rx_a); end
    checks++; if (ss_n_b !== 4'b1111 || rx_b !== 16'h0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_b got=%b %h %b exp=1111 0000 0", ss_n_b, rx_b, busy_b); end
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (sclk_a !== 1'b0 || busy_a !== 1'b0 || ss_n_a !== 3'b111) begin failures++; $display("FAIL idle_after_reset got=%b %b %b exp=0 0 111", sclk_a, busy_a, ss_n_a); end
  endtask
  task automatic test_err;
    sel_a = 2'd3; tx_a = 8'h77; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++; if (err_a !== 1'b1 || busy_a !== 1'b0 || ss_n_a !== 3'b111) begin failures++; $display("FAIL err_pulse got=%b %b %b exp=1 0 111", err_a, busy_a, ss_n_a); end
    @(posedge clk); #1;
    checks++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b %b exp=0 0", err_a, busy_a); end
  endtask
  task automatic test_reset_abort;
    int edges, dones;
    logic prev;
    edges = 0; dones = 0;
    cpol_a = 0; cpha_a = 0; lsb_a = 0; div_a = 8'd1; sel_a = 2'd2; tx_a = 8'h5A;
    s_cpol = 0; s_cpha = 0; s_lsb = 0; s_word = 8'h66;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    prev = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (sclk_a !== prev) begin edges++; prev = sclk_a; end
      if (edges == 7) break;
      @(posedge clk); #1;
    end
    checks++; if (edges != 7 || sclk_a !== 1'b1) begin failures++; $display("FAIL abort_reach_edge7 got=%0d sclk=%b exp=7 1", edges, sclk_a); end
    reset = 1'b1;
    #1;
    checks++; if ({sclk_a, mosi_a, busy_a, done_a} !== 4'b0 || ss_n_a !== 3'b111 || rx_a !== 8'h00) begin failures++; $display("FAIL abort_outputs got=%b %b %h exp=0000 111 00", {sclk_a, mosi_a, busy_a, done_a}, ss_n_a, rx_a); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_a) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones != 0 || busy_a !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0d busy=%b exp=0 0", dones, busy_a); end
    xfer_a(1'b0, 1'b1, 1'b0, 8'd1, 2'd2, 8'h3E, 8'hD1, 0, 1'b0, "after_abort");
  endtask
  initial begin
    test_reset;
    xfer_a(1'b0, 1'b0, 1'b0, 8'd0, 2'd1, 8'hC3, 8'h3C, 0, 1'b0, "mode0");
    xfer_a(1'b1, 1'b1, 1'b1, 8'd3, 2'd0, 8'h81, 8'h5A, 0, 1'b0, "mode3_lsb");
    xfer_a(1'b0, 1'b1, 1'b0, 8'd1, 2'd2, 8'hA5, 8'h96, 5, 1'b0, "start_while_busy");
    test_err;
    xfer_a(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h12, 8'hA7, 0, 1'b1, "b2b_first");
    xfer_a(1'b1, 1'b0, 1'b1, 8'd2, 2'd1, 8'h34, 8'h5C, 0, 1'b0, "b2b_second");
    xfer_b(1'b0, 1'b1, 8'd1, 16'hBEEF, "wide_mode1");
    xfer_b(1'b1, 1'b0, 8'd2, 16'hBEEF, "wide_mode2");
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master, the next generation of the team's fixed 8-bit, 3-slave SPI master. Adds configurable word width, slave count and SCLK divider, all four CPOL/CPHA modes latched per transfer, MSB/LSB-first ordering, and a start/busy/done handshake. It sits between the system controller and the SPI slave bank. It replaces the load-based master in the SPI integration bench.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_SS, 3, number of slave-select lines (>=1)
DIV_W, 8, width of clk_div
SEL_W, 2, width of ss_sel (>= clog2(NUM_SS))

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
CPOL  in  1  SCLK idle level, latched at start
CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at start
lsb_first  in  1  1: LSB shifted first, latched at start
clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles, latched at start
ss_sel  in  SEL_W  target slave index, latched at start
start  in  1  transfer request, sampled in IDLE only
tx_data  in  DATA_W  word to send, latched at start
rx_data  out  DATA_W  last received word, stable until next done
busy  out  1  transfer in progress
done  out  1  one-cycle pulse, transfer complete
err  out  1  one-cycle pulse, start rejected because ss_sel >= NUM_SS
sclk  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in
ss_n  out  NUM_SS  active-low slave selects

Behaviour:
- Reset values: sclk=0 while reset is asserted, then the latched CPOL (0 until the first start). ss_n all 1s. mosi=0. busy=0, done=0, err=0. rx_data=0. FSM=IDLE. Reset mid-transfer aborts immediately; no done pulse is generated.
- Let H = clk_div+1 and W = DATA_W.
- States: IDLE, SETUP, XFER, FINISH.
- IDLE:
  - sclk=CPOL_latched, ss_n all 1s.
  - start=1 with ss_sel<NUM_SS in cycle T: latch all configuration and tx_data, then go to SETUP.
  - start=1 with ss_sel>=NUM_SS: err=1 in cycle T+1; stay in IDLE; ss_n is untouched.
- SETUP, entered at T+1:
  - busy=1, ss_n[ss_sel]=0.
  - CPHA=0: mosi drives the first bit at T+1.
  - Lasts H cycles, then go to XFER.
- XFER:
  - 2W SCLK edges, one every H cycles; first edge at T+1+H, last edge at T+1+2W*H.
  - Odd-numbered edges are leading, even-numbered edges are trailing.
  - CPHA=0: sample miso on leading edges; drive next mosi bit on trailing edges, except the final trailing edge.
  - CPHA=1: drive mosi on leading edges; sample on trailing edges.
  - A sample stores the miso value present in the clk cycle the edge is generated.
  - Bit order follows lsb_first; received bits are assembled in the same order.
- FINISH:
  - Hold one further H cycles with sclk at idle level.
  - At cycle T+1+(2W+1)*H: ss_n all 1s, busy=0, done=1 for that one cycle, rx_data updated in the same cycle, return to IDLE.
  - A start in the done cycle is accepted (back-to-back transfers).
- Total busy duration is (2W+1)*H cycles.
- Input changes to CPOL/CPHA/clk_div/ss_sel/tx_data/lsb_first while busy are ignored.
- start while busy is ignored, with no err pulse.
- clk_div=all-ones: the half-period counter is DIV_W+1 bits wide, so there is no wrap.
- mosi keeps its last bit after the transfer until the next SETUP.

Test Plan:
- Mode 0, clk_div=0, W=8, slave model returns 0x3C, tx_data=0xC3, ss_sel=1 -> ss_n=3'b101 for 17 cycles, 16 sclk edges, done at T+18, rx_data=0x3C, and the slave receives 0xC3.
- Mode 3, clk_div=3, lsb_first=1, tx_data=0x81, slave returns 0x5A LSB-first -> sclk idles 1, edge spacing 4 cycles, busy for 68 cycles, rx_data=0x5A.
- Instance with DATA_W=16, NUM_SS=4: loopback miso=mosi, tx_data=0xBEEF in modes 1 and 2 -> rx_data=0xBEEF, done after 33*H cycles.
- start pulsed again mid-transfer with a new tx_data=0xFF -> ignored; the original word completes; exactly one done pulse.
- reset asserted at edge 7 of a transfer -> outputs at reset values within the same cycle, no done; a following start transfers correctly.
- ss_sel=3 with NUM_SS=3 -> err pulse at T+1, ss_n stays 3'b111, busy stays 0; done issued on back-to-back starts, both words correct.
